// File: rtl/iram_loader.sv
// iram_loader
//   Assembles a byte stream into 32-bit little-endian words and writes them
//   into an instruction RAM, starting at a word address captured with start.
//   A flush ends the session, committing any partially filled word with
//   byte-lane enables for the lanes that were actually filled.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             begin a session (honoured only while idle)
//   base_addr_i         word address of the first word, captured with start_i
//   byte_valid_i        byte offered on byte_data_i
//   byte_data_i         byte of the program image
//   byte_ready_o        loader accepts a byte this cycle
//   flush_i             end of stream
//   wr_en_o             RAM write strobe (registered)
//   wr_addr_o           RAM word address (registered)
//   wr_data_o           RAM write data, zero when no write (registered)
//   wr_byte_en_o        RAM byte-lane enables, zero when no write (registered)
//   busy_o              session in progress
//   done_o              one-cycle pulse at session end
//   overflow_o          sticky: session reached capacity, further bytes refused
//   word_cnt_o          words written in the current or last session
module iram_loader #(
  parameter int XLEN      = 32,
  parameter int MAX_WORDS = 8192
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] base_addr_i,
  input  logic            byte_valid_i,
  input  logic [7:0]      byte_data_i,
  output logic            byte_ready_o,
  input  logic            flush_i,
  output logic            wr_en_o,
  output logic [XLEN-1:0] wr_addr_o,
  output logic [XLEN-1:0] wr_data_o,
  output logic [3:0]      wr_byte_en_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            overflow_o,
  output logic [XLEN-1:0] word_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  localparam logic [XLEN-1:0] MaxWordsW = XLEN'(MAX_WORDS);

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      lane_q, lane_d;
  logic [23:0]     buf_q, buf_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            wr_en_q, wr_en_d;
  logic [XLEN-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [3:0]      wr_be_q, wr_be_d;
  logic            byte_ready;
  logic            byte_accept;

  assign byte_ready  = (state_q == S_LOAD) && !ovf_q;
  assign byte_accept = byte_ready && byte_valid_i;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lane_d    = lane_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = '0;
    wr_be_d   = 4'b0000;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          addr_d  = base_addr_i;
          lane_d  = 2'd0;
          buf_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      S_LOAD: begin
        if (byte_accept) begin
          if (lane_q == 2'd3) begin
            // Lane 3 completes the word; the write leaves on the next edge
            // while lane 0 of the following word is already free.
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = XLEN'({byte_data_i, buf_q});
            wr_be_d   = 4'b1111;
            addr_d    = addr_q + XLEN'(1);
            cnt_d     = cnt_q + XLEN'(1);
            lane_d    = 2'd0;
            buf_d     = '0;
            if (cnt_d == MaxWordsW) ovf_d = 1'b1;
          end else begin
            case (lane_q)
              2'd0:    buf_d[7:0]   = byte_data_i;
              2'd1:    buf_d[15:8]  = byte_data_i;
              default: buf_d[23:16] = byte_data_i;
            endcase
            lane_d = lane_q + 2'd1;
          end
        end
        // A byte taken in the same cycle is already packed above, so the
        // flush sees the updated lane index.
        if (flush_i) state_d = S_FLUSH;
      end

      S_FLUSH: begin
        // Unfilled lanes of buf_q are still zero from the last clear.
        if (lane_q != 2'd0 && !ovf_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = XLEN'({8'h00, buf_q});
          case (lane_q)
            2'd1:    wr_be_d = 4'b0001;
            2'd2:    wr_be_d = 4'b0011;
            default: wr_be_d = 4'b0111;
          endcase
          addr_d = addr_q + XLEN'(1);
          cnt_d  = cnt_q + XLEN'(1);
          if (cnt_d == MaxWordsW) ovf_d = 1'b1;
        end
        lane_d  = 2'd0;
        buf_d   = '0;
        state_d = S_DONE;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      lane_q    <= 2'd0;
      buf_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= 4'b0000;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lane_q    <= lane_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
    end
  end

  assign byte_ready_o = byte_ready;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign wr_byte_en_o = wr_be_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign overflow_o   = ovf_q;
  assign word_cnt_o   = cnt_q;

endmodule
